// File: rtl/run_controller.sv
// run_controller -- run/step/halt sequencer for a small single-cycle core.
//
// Decides when the core may retire an instruction (pc_en) from level run
// requests, a halt instruction (16'hFFFF) and an optional address breakpoint.
// Also keeps saturating counts of retired instructions and active cycles.
//
// Optional feature: define RUN_CONTROLLER_BREAKPOINT_EN to enable the
// breakpoint compare and the skip-on-resume register. Without it bp_addr and
// bp_valid are accepted but ignored.
//
// Ports:
//   clk            - clock, all state on rising edge
//   reset          - synchronous active-high reset
//   start          - level request: run continuously
//   step           - level request: retire one instruction
//   stop           - level request: halt (highest priority)
//   curr_inst_addr - current instruction address (5b)
//   curr_inst      - current instruction word (16b)
//   bp_addr        - breakpoint address (5b)
//   bp_valid       - breakpoint enable
//   pc_en          - retire enable: PC load plus register/memory writes
//   state          - IDLE=00 RUN=01 STEP=10 HALTED=11
//   halted         - high only in HALTED
//   retired_count  - saturating count of retired instructions
//   cycle_count    - saturating count of cycles spent in RUN or STEP
module run_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic        stop,
    input  logic [4:0]  curr_inst_addr,
    input  logic [15:0] curr_inst,
    input  logic [4:0]  bp_addr,
    input  logic        bp_valid,
    output logic        pc_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] retired_count,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t cur_state, nxt_state;
    logic   is_halt;
    logic   bp_hit;
    logic   active;

    assign is_halt = (curr_inst == 16'hFFFF);
    assign active  = (cur_state == RUN) || (cur_state == STEP);

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
    logic skip_bp;

    // skip_bp masks the breakpoint for the first active cycle after a resume,
    // so resuming while sitting on the breakpoint address makes progress.
    always_ff @(posedge clk) begin
        if (reset)
            skip_bp <= 1'b0;
        else if (cur_state == HALTED && (nxt_state == RUN || nxt_state == STEP))
            skip_bp <= 1'b1;
        else if (active)
            skip_bp <= 1'b0;
    end

    assign bp_hit = bp_valid && (curr_inst_addr == bp_addr) && !skip_bp;
`else
    logic unused_bp;

    assign unused_bp = ^{bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    // pc_en depends only on state and instruction/address inputs, never on
    // the request lines, so commands take effect from the next cycle.
    always_comb begin
        nxt_state = cur_state;
        pc_en     = 1'b0;
        halted    = 1'b0;
        case (cur_state)
            IDLE: begin
                if (stop)       nxt_state = IDLE;
                else if (start) nxt_state = RUN;
                else if (step)  nxt_state = STEP;
            end
            RUN: begin
                pc_en = !is_halt && !bp_hit;
                if (stop || is_halt || bp_hit)
                    nxt_state = HALTED;
            end
            STEP: begin
                pc_en     = !is_halt && !bp_hit;
                nxt_state = HALTED;
            end
            HALTED: begin
                halted = 1'b1;
                if (stop)       nxt_state = HALTED;
                else if (start) nxt_state = RUN;
                else if (step)  nxt_state = STEP;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= 16'h0000;
            cycle_count   <= 16'h0000;
        end else begin
            if (pc_en && retired_count != 16'hFFFF)
                retired_count <= retired_count + 16'd1;
            if (active && cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL use port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL use port reset, input, 1 bit, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL use port start, input, 1 bit, a level request to run continuously.
REQ-004 The block SHALL use port step, input, 1 bit, a level request to retire exactly one instruction.
REQ-005 The block SHALL use port stop, input, 1 bit, a level request to halt.
REQ-006 The block SHALL use port curr_inst_addr, input, 5 bits, the current instruction address.
REQ-007 The block SHALL use port curr_inst, input, 16 bits, the current instruction word.
REQ-008 The block SHALL use port bp_addr, input, 5 bits, the breakpoint address.
REQ-009 The block SHALL use port bp_valid, input, 1 bit, the breakpoint enable.
REQ-010 The block SHALL use port pc_en, output, 1 bit: when high, the PC loads next_inst_addr and register-file and data-memory writes are allowed.
REQ-011 The block SHALL use port state, output, 2 bits: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-012 The block SHALL use port halted, output, 1 bit, high only when state is HALTED.
REQ-013 The block SHALL use port retired_count, output, 16 bits, the number of retired instructions.
REQ-014 The block SHALL use port cycle_count, output, 16 bits, the number of cycles spent in RUN or STEP.

Function
REQ-015 The halt instruction SHALL be curr_inst == 16'hFFFF; is_halt is combinational.
REQ-016 bp_hit SHALL be bp_valid & (curr_inst_addr == bp_addr) & ~skip_bp, where skip_bp is a 1-bit register.
REQ-017 pc_en SHALL be combinational: (state==RUN | state==STEP) & ~is_halt & ~bp_hit.
REQ-018 An instruction SHALL retire in any cycle with pc_en high, with zero added latency.
REQ-019 Command priority SHALL be stop > start > step when requests are sampled together.
REQ-020 In IDLE: start goes to RUN; step goes to STEP; stop, or no request, stays in IDLE.
REQ-021 In RUN: stop, is_halt or bp_hit goes to HALTED; otherwise the block stays in RUN.
REQ-022 In RUN, the instruction in the cycle where stop is sampled SHALL retire unless is_halt or bp_hit is also true.
REQ-023 STEP SHALL last exactly one cycle and then go to HALTED unconditionally, whether or not that cycle retired.
REQ-024 In HALTED: stop stays in HALTED; otherwise start goes to RUN and step goes to STEP.
REQ-025 skip_bp SHALL be set on any transition from HALTED into RUN or STEP, and cleared after the first cycle in RUN or STEP, so a resume at the breakpoint address retires that instruction.
REQ-026 A halt instruction SHALL never retire; with start held, the block re-enters RUN and returns to HALTED each time, with pc_en low throughout.
REQ-027 retired_count SHALL increment by 1 on each retiring cycle and saturate at 16'hFFFF.
REQ-028 cycle_count SHALL increment by 1 in each cycle with state RUN or STEP, and saturate at 16'hFFFF.
REQ-029 All registers SHALL be updated only on the rising edge of clk; there SHALL be no combinational path from start, step or stop to pc_en.

Reset
REQ-030 When reset is high at a rising edge: state=IDLE, skip_bp=0, retired_count=0, cycle_count=0, and consequently pc_en=0 and halted=0.
REQ-031 Reset SHALL override every request; a reset asserted mid-RUN SHALL give pc_en=0 from the cycle after the edge, and no counter increment for that edge.

Configuration
REQ-032 With macro RUN_CONTROLLER_BREAKPOINT_EN defined, breakpoint logic SHALL be as in REQ-016 and REQ-025.
REQ-033 Without that macro, bp_hit SHALL be constant 0, skip_bp SHALL be absent, and bp_addr and bp_valid SHALL remain as ports but be ignored.

Verification
REQ-034 Reset, then start held, with 5 ordinary instructions followed by 16'hFFFF -> retired_count=5, state=HALTED, pc_en=0 at the halt address.
REQ-035 From HALTED, pulse step for one cycle on an ordinary instruction -> exactly one pc_en cycle, retired_count+1, cycle_count+1, state back to 11.
REQ-036 With the macro defined, bp_valid=1 and bp_addr=5'd3, run from address 0 -> halt with curr_inst_addr=3 and retired_count=3; then start -> address 3 retires and running continues.
REQ-037 start, step and stop all high in IDLE -> state stays 00 and pc_en=0; start and step high -> state 01.
REQ-038 Preload retired_count to 16'hFFFE via run, retire 3 instructions -> count holds 16'hFFFF; then assert reset in RUN -> next cycle state=00, both counts=0, pc_en=0.
